// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared widths, FSM state encoding and timeout constant for the exponential job sequencer
package exp_pkg;

  localparam int EXP_XW = 16;
  localparam int EXP_IW = 2;
  localparam int EXP_FW = 16;

  localparam logic [EXP_IW+EXP_FW-1:0] EXP_SAT = 18'h3FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/exp_job_fifo.sv
// rtl/exp_job_fifo.sv - synchronous operand FIFO; pushes while full are dropped, pops while empty are ignored
module exp_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/exp_job_sequencer.sv
// rtl/exp_job_sequencer.sv - buffers operands, issues one job at a time to the exponential accelerator, holds each result
// Optional watchdog under EXP_SEQ_TIMEOUT_EN: after TIMEOUT cycles in WAIT an 18'h3FFFF result with err=1 is substituted.
module exp_job_sequencer
  import exp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_XW-1:0]        in_x,
  output logic                     acc_start,
  output logic [EXP_XW-1:0]        acc_x,
  input  logic                     acc_done,
  input  logic [EXP_IW-1:0]        acc_intpart,
  input  logic [EXP_FW-1:0]        acc_fracpart,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_IW+EXP_FW-1:0] out_data,
  output logic                     err,
  output logic                     busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EXP_XW-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;

`ifdef EXP_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
`else
  assign err = 1'b0;
`endif

  assign in_ready = !fifo_full;
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
  assign busy     = (state != ST_IDLE) || (fifo_count != '0);

  exp_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EXP_XW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_x),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      acc_start <= 1'b0;
      acc_x     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef EXP_SEQ_TIMEOUT_EN
      err       <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      acc_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            acc_x     <= fifo_head;
            acc_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef EXP_SEQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the expiry cycle takes priority over the timeout.
          if (acc_done) begin
            out_data  <= {acc_intpart, acc_fracpart};
            out_valid <= 1'b1;
            state     <= ST_HOLD;
`ifdef EXP_SEQ_TIMEOUT_EN
            err       <= 1'b0;
          end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
            out_data  <= EXP_SAT;
            out_valid <= 1'b1;
            err       <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            wd_cnt    <= wd_cnt + 1'b1;
`endif
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_job_sequencer.sv
// tb/tb_exp_job_sequencer.sv - directed self-checking bench for exp_job_sequencer with a stub accelerator
module tb_exp_job_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_x = '0;
  logic        acc_done = 1'b0;
  logic [1:0]  acc_intpart = '0;
  logic [15:0] acc_fracpart = '0;
  logic        auto_ready = 1'b0;
  logic        man_ready = 1'b0;
  logic        out_ready;
  logic        in_ready, acc_start, out_valid, err, busy;
  logic [15:0] acc_x;
  logic [17:0] out_data;

  assign out_ready = auto_ready | man_ready;

  always #5 clk = ~clk;

  exp_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .acc_start(acc_start), .acc_x(acc_x), .acc_done(acc_done),
    .acc_intpart(acc_intpart), .acc_fracpart(acc_fracpart),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int stub_lat = 5;
  int stub_cnt = 0;
  bit stub_kick = 1'b0;
  int n_starts = 0;
  int n_results = 0;
  logic [15:0] start_log[$];
  logic [17:0] res_log[$];
  logic        err_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] stub_result(input logic [15:0] x);
    case (x)
      16'hFFFF: return 18'h2B7E1;
      16'hBD70: return 18'h2188D;
      16'h3333: return 18'h138AE;
      default:  return {2'b01, x ^ 16'h5A5A};
    endcase
  endfunction

  function automatic logic [31:0] res_at(input int i);
    return (i < res_log.size()) ? 32'(res_log[i]) : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] start_at(input int i);
    return (i < start_log.size()) ? 32'(start_log[i]) : 32'hDEAD_DEAD;
  endfunction

  // Stub accelerator and result collector, both evaluated on the falling edge.
  initial forever begin
    @(negedge clk);
    acc_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) acc_done = 1'b1;
    end
    if (stub_kick) begin
      stub_kick = 1'b0;
      acc_done  = 1'b1;
    end
    if (acc_start) begin
      start_log.push_back(acc_x);
      n_starts++;
      {acc_intpart, acc_fracpart} = stub_result(acc_x);
      stub_cnt = stub_lat;
    end
    if (auto_ready && out_valid) begin
      res_log.push_back(out_data);
      err_log.push_back(err);
      n_results++;
    end
  end

  task automatic push1(input logic [15:0] v);
    @(negedge clk); in_valid = 1'b1; in_x = v;
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_results(input string tag, input int n, input int budget);
    int k = 0;
    while (n_results < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(n_results >= n), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!acc_start && k < budget);
    check(tag, 32'(acc_start), 32'd1);
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int k = 0;
    while (!out_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int sb, rb, acc_n;
    bit ov_seen;
    logic [17:0] t3_exp [5];
    t3_exp = '{18'h15A5B, 18'h15A58, 18'h15A59, 18'h15A5E, 18'h15A5F};

    // Reset state (checked while reset is still asserted)
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_acc_start", 32'(acc_start), 32'd0);
    check("rst_acc_x", 32'(acc_x), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // Single job with the 20-cycle stub
    auto_ready = 1'b1;
    stub_lat   = 20;
    push1(16'hFFFF);
    check("t1_start_early", 32'(acc_start), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_start_pulse", 32'(acc_start), 32'd1);
    check("t1_acc_x", 32'(acc_x), 32'hFFFF);
    @(negedge clk);
    check("t1_start_one_cycle", 32'(acc_start), 32'd0);
    repeat (10) @(negedge clk);
    check("t1_acc_x_held", 32'(acc_x), 32'hFFFF);
    check("t1_no_early_result", 32'(out_valid), 32'd0);
    wait_results("t1_wait", 1, 40);
    check("t1_starts", 32'(n_starts), 32'd1);
    check("t1_data", res_at(0), 32'h2B7E1);
    check("t1_err", 32'(err_log.size() > 0 ? err_log[0] : 1'b1), 32'd0);

    // Back-to-back jobs
    repeat (4) @(negedge clk);
    stub_lat = 5;
    sb = n_starts;
    rb = n_results;
    @(negedge clk); in_valid = 1'b1; in_x = 16'hFFFF;
    check("t2_ready0", 32'(in_ready), 32'd1);
    @(negedge clk); in_x = 16'hBD70;
    check("t2_ready1", 32'(in_ready), 32'd1);
    @(negedge clk); in_x = 16'h3333;
    check("t2_ready2", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    wait_results("t2_wait", rb + 3, 100);
    check("t2_starts", 32'(n_starts - sb), 32'd3);
    check("t2_start0", start_at(sb), 32'hFFFF);
    check("t2_start1", start_at(sb + 1), 32'hBD70);
    check("t2_start2", start_at(sb + 2), 32'h3333);
    check("t2_res0", res_at(rb), 32'h2B7E1);
    check("t2_res1", res_at(rb + 1), 32'h2188D);
    check("t2_res2", res_at(rb + 2), 32'h138AE);

    // Full FIFO: one operand in service, DEPTH buffered, the last push refused
    repeat (4) @(negedge clk);
    stub_lat = 0;
    sb = n_starts;
    rb = n_results;
    acc_n = 0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = 16'(i);
      if (in_ready) acc_n++;
    end
    @(negedge clk); in_valid = 1'b0;
    check("t3_accepted", 32'(acc_n), 32'(DEPTH + 1));
    check("t3_in_ready_full", 32'(in_ready), 32'd0);
    check("t3_one_in_service", 32'(n_starts - sb), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    stub_lat  = 3;
    stub_kick = 1'b1;
    wait_results("t3_wait", rb + 5, 200);
    repeat (10) @(negedge clk);
    check("t3_result_count", 32'(n_results - rb), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("t3_res%0d", i), res_at(rb + i), 32'(t3_exp[i]));

    // Output backpressure in HOLD
    auto_ready = 1'b0;
    stub_lat   = 3;
    @(negedge clk); in_valid = 1'b1; in_x = 16'h0010;
    @(negedge clk); in_x = 16'h0020;
    @(negedge clk); in_valid = 1'b0;
    wait_out_valid("t4_wait0", 50);
    check("t4_data0", 32'(out_data), 32'h15A4A);
    sb = n_starts;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_data", 32'(out_data), 32'h15A4A);
      check("t4_hold_nostart", 32'(acc_start), 32'd0);
    end
    check("t4_hold_starts", 32'(n_starts), 32'(sb));
    man_ready = 1'b1;
    @(negedge clk); man_ready = 1'b0;
    check("t4_release_valid", 32'(out_valid), 32'd0);
    check("t4_bubble", 32'(acc_start), 32'd0);
    @(negedge clk);
    check("t4_next_issue", 32'(acc_start), 32'd1);
    check("t4_next_x", 32'(acc_x), 32'h0020);
    wait_out_valid("t4_wait1", 50);
    check("t4_data1", 32'(out_data), 32'h15A7A);
    check("t4_err1", 32'(err), 32'd0);
    man_ready = 1'b1;
    @(negedge clk); man_ready = 1'b0;

    // Reset during WAIT; the stub still delivers its late done
    repeat (4) @(negedge clk);
    auto_ready = 1'b1;
    stub_lat   = 15;
    push1(16'h0042);
    wait_start("t5_start", 10);
    repeat (5) @(negedge clk);
    sb = n_starts;
    rb = n_results;
    rst = 1'b0;
    #1;
    check("t5_rst_acc_start", 32'(acc_start), 32'd0);
    check("t5_rst_acc_x", 32'(acc_x), 32'd0);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_out_data", 32'(out_data), 32'd0);
    check("t5_rst_err", 32'(err), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ov_seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      ov_seen |= out_valid;
    end
    check("t5_stale_done_ignored", 32'(ov_seen), 32'd0);
    check("t5_no_results", 32'(n_results), 32'(rb));
    check("t5_no_starts", 32'(n_starts), 32'(sb));
    check("t5_idle", 32'(busy), 32'd0);

`ifdef EXP_SEQ_TIMEOUT_EN
    // Watchdog: the stub never answers
    auto_ready = 1'b0;
    stub_lat   = 0;
    push1(16'h0077);
    wait_start("t6_start", 10);
    repeat (64) @(negedge clk);
    check("t6_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_err", 32'(err), 32'd1);
    check("t6_data", 32'(out_data), 32'h3FFFF);
    man_ready = 1'b1;
    @(negedge clk); man_ready = 1'b0;
    check("t6_released", 32'(out_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exp_job_sequencer.md
# exp_job_sequencer

Upstream feeder and result collector for the `exponential` accelerator. It buffers incoming 16-bit fractional operands (unsigned Q0.16) in a small FIFO and issues them one at a time to the accelerator: a one-cycle `start` pulse, with `x` held stable until `done`. It captures `{intpart, fracpart}` on `done` and presents it downstream over a valid/ready handshake. This lets a producer stream operands without tracking accelerator latency.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: watchdog limit in cycles; used only when the watchdog macro is defined.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  FIFO can accept.
- `in_x`  in  16  operand, unsigned Q0.16.
- `acc_start`  out  1  one-cycle start pulse to accelerator.
- `acc_x`  out  16  operand to accelerator; held from ISSUE until WAIT exits.
- `acc_done`  in  1  accelerator completion pulse.
- `acc_intpart`  in  2  accelerator result, integer part.
- `acc_fracpart`  in  16  accelerator result, fractional part.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  18  `{intpart, fracpart}`.
- `err`  out  1  result is a timeout substitute; qualified by `out_valid`.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- **IDLE:** when the FIFO is non-empty, pop the head into `acc_x`, then go to ISSUE.
- **ISSUE:** `acc_start` = 1 for exactly this cycle, then go to WAIT.
- **WAIT:** on `acc_done`, register `{acc_intpart, acc_fracpart}` into `out_data`, set `out_valid`, `err` = 0, then go to HOLD.
- **HOLD:** `out_data`, `out_valid` and `err` stay stable. On `out_valid & out_ready`, clear `out_valid` and go to IDLE.
- `acc_done` outside WAIT is ignored.
- FIFO push on `in_valid & in_ready`, with `in_ready` = !full. A push while full is rejected even if a pop happens in the same cycle.
- Simultaneous push and pop (not full) leaves the count unchanged.
- Pointers wrap modulo DEPTH. The count is `$clog2(DEPTH)+1` bits wide.
- Ordering: results leave in operand order. No reordering, and only one job is in flight.
- Reset (any state, including mid-WAIT):
  - FIFO emptied, state IDLE, `acc_start` 0, `acc_x` 0, `out_valid` 0, `out_data` 0, `err` 0, `busy` 0.
  - `in_ready` is 1 while reset is asserted.
  - An accelerator computation in progress is abandoned. Its late `done` is ignored because the FSM is in IDLE.

## Timing
- Operand pushed at edge N into an empty FIFO with FSM idle:
  - pop/ISSUE entered at N+1;
  - `acc_start` high N+1→N+2;
  - WAIT from N+2.
- `acc_done` sampled high at edge M → `out_valid` high after M.
- HOLD → IDLE → ISSUE costs one bubble cycle between jobs.
- All outputs are registered except `in_ready` and `busy`, which are combinational from registered state and count.

## Configuration
- Macro: `EXP_SEQ_TIMEOUT_EN`.
- **Defined:** a cycle counter runs in WAIT and is cleared on entry. If `TIMEOUT` cycles pass without `acc_done`, the block loads `out_data` = 18'h3FFFF, sets `err` = 1, raises `out_valid`, and goes to HOLD. An `acc_done` in the same cycle as expiry wins (normal result, `err` = 0).
- **Undefined:** no counter, WAIT waits indefinitely, and `err` is tied to 0.

## Structure
- Shared package `exp_pkg` holds:
  - FSM state enum;
  - widths `EXP_XW`=16, `EXP_IW`=2, `EXP_FW`=16;
  - timeout saturation constant 18'h3FFFF.
- One sub-module, `exp_job_fifo`: synchronous FIFO with parameters DEPTH/width, push/pop, full/empty and count.

## Test plan
- **Single job.** Reset, then push `in_x`=16'hFFFF with a stub accelerator returning done 20 cycles after start with `{2'd2, 16'hB7E1}`. Required: one `acc_start` pulse, `acc_x`=16'hFFFF held through WAIT, `out_data`=18'h2B7E1, `err`=0.
- **Back-to-back jobs.** Push 16'hFFFF, 16'hBD70 and 16'h3333 on consecutive cycles. Required: `in_ready` stays 1, three start pulses in order, and results leave in push order.
- **Full FIFO.** With the stub stalled, push DEPTH+2 operands. Required: one enters service and DEPTH are buffered, so `in_ready`=0 once full; the extra push is not accepted.
- **Output backpressure.** Hold `out_ready`=0 for 10 cycles in HOLD. Required: `out_data` stable and no new `acc_start`; release → next ISSUE two cycles later.
- **Reset mid-WAIT.** Assert `rst`=0 during WAIT and deliver `acc_done` after release. Required: all outputs at reset values, the stale done is ignored, and `out_valid` stays 0.
- **Timeout (with `EXP_SEQ_TIMEOUT_EN`, TIMEOUT=64).** Stub never asserts done. Required: `out_valid`=1, `err`=1, `out_data`=18'h3FFFF 64 cycles after WAIT entry.
